// File: rtl/updown_counter_param_if.sv
// updown_counter_param_if: control, limit and status bundle for the parametrised up/down counter
interface updown_counter_param_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              en;
    logic              up;
    logic [STEP_W-1:0] step;
    logic              clr;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  lo_limit;
    logic [WIDTH-1:0]  hi_limit;
    logic              sat_mode;
    logic [WIDTH-1:0]  count;
    logic              at_max;
    logic              at_min;
    logic              wrap_p;
    logic              ovf_sticky;
    logic              cfg_err;
    modport master (
        output en, up, step, clr, load, load_val, lo_limit, hi_limit, sat_mode,
        input  count, at_max, at_min, wrap_p, ovf_sticky, cfg_err
    );
    modport slave (
        input  en, up, step, clr, load, load_val, lo_limit, hi_limit, sat_mode,
        output count, at_max, at_min, wrap_p, ovf_sticky, cfg_err
    );
endinterface

// File: rtl/updown_counter_param.sv
// updown_counter_param: up/down counter with step, runtime limits, wrap/saturate, load/clear and status flags
module updown_counter_param #(
    parameter int               WIDTH     = 8,
    parameter int               STEP_W    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                   clk,
    input logic                   rst,
    updown_counter_param_if.slave bus
);
    logic [WIDTH-1:0] count_q, clamped, stepped, nxt;
    logic [WIDTH:0]   step_x, sum, lo_sum;
    logic             cfg_err, step_ok, hit, wrap_q, ovf_q;
    assign cfg_err = bus.lo_limit > bus.hi_limit;
    assign step_x  = (WIDTH+1)'(bus.step);
    // Compare at WIDTH+1 bits so neither count+step nor lo_limit+step can overflow
    assign sum     = {1'b0, count_q} + step_x;
    assign lo_sum  = {1'b0, bus.lo_limit} + step_x;
    assign step_ok = bus.en && !cfg_err && (bus.step != '0);
    assign hit     = step_ok && (bus.up ? (sum > {1'b0, bus.hi_limit}) : ({1'b0, count_q} < lo_sum));
    assign stepped = bus.up ? sum[WIDTH-1:0] : count_q - step_x[WIDTH-1:0];
    assign clamped = bus.load_val < bus.lo_limit ? bus.lo_limit :
                     bus.load_val > bus.hi_limit ? bus.hi_limit : bus.load_val;
    always_comb begin
        nxt = bus.clr  ? bus.lo_limit :
              bus.load ? (cfg_err ? bus.load_val : clamped) :
              hit      ? ((bus.sat_mode ~^ bus.up) ? bus.hi_limit : bus.lo_limit) :
              step_ok  ? stepped : count_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= nxt;
            wrap_q  <= !bus.clr && !bus.load && hit;
            ovf_q   <= bus.clr ? 1'b0 : (ovf_q || (!bus.load && hit));
        end
    end
    assign bus.count      = count_q;
    assign bus.wrap_p     = wrap_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.cfg_err    = cfg_err;
    assign bus.at_max     = count_q == bus.hi_limit;
    assign bus.at_min     = count_q == bus.lo_limit;
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed and random checks of the up/down counter against an integer reference model
module tb_updown_counter_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int m = 0, m_wrap = 0, m_ovf = 0;
    bit in_range = 0;
    updown_counter_param_if #(.WIDTH(4), .STEP_W(2)) bus();
    updown_counter_param #(.WIDTH(4), .STEP_W(2), .RESET_VAL(4'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic set_in(input bit en, input bit up, input int step, input bit clr, input bit load,
                          input int lv, input int lo, input int hi, input bit sat);
        bus.en = en; bus.up = up; bus.step = 2'(step); bus.clr = clr; bus.load = load;
        bus.load_val = 4'(lv); bus.lo_limit = 4'(lo); bus.hi_limit = 4'(hi); bus.sat_mode = sat;
    endtask
    task automatic tick();
        int lo, hi, st, lv;
        bit cfg;
        lo = int'(bus.lo_limit); hi = int'(bus.hi_limit); st = int'(bus.step); lv = int'(bus.load_val);
        cfg = lo > hi;
        @(posedge clk);
        #1;
        m_wrap = 0;
        if (bus.clr) begin
            m = lo; m_ovf = 0; in_range = !cfg;
        end else if (bus.load) begin
            m = cfg ? lv : (lv < lo ? lo : (lv > hi ? hi : lv));
            in_range = !cfg;
        end else if (bus.en && !cfg && st > 0) begin
            if (bus.up ? (m + st > hi) : (m < lo + st)) begin
                m = (bus.sat_mode == bus.up) ? hi : lo;
                m_wrap = 1; m_ovf = 1;
            end else m = bus.up ? m + st : m - st;
        end
        check("count", int'(bus.count), m);
        check("wrap_p", int'(bus.wrap_p), m_wrap);
        check("ovf_sticky", int'(bus.ovf_sticky), m_ovf);
        check("at_max", int'(bus.at_max), int'(m == int'(bus.hi_limit)));
        check("at_min", int'(bus.at_min), int'(m == int'(bus.lo_limit)));
        check("cfg_err", int'(bus.cfg_err), int'(bus.lo_limit > bus.hi_limit));
    endtask
    initial begin
        set_in(0, 1, 1, 0, 0, 0, 0, 15, 0);
        #12;
        check("reset_count", int'(bus.count), 0);
        check("reset_wrap", int'(bus.wrap_p), 0);
        check("reset_ovf", int'(bus.ovf_sticky), 0);
        rst = 1'b0;
        // free-running wrap from 15 back to 0
        bus.en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("t1_seq", int'(bus.count), i % 16);
        end
        check("t1_wrap", int'(bus.wrap_p), 1);
        tick();
        check("t1_wrap_off", int'(bus.wrap_p), 0);
        check("t1_ovf", int'(bus.ovf_sticky), 1);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("async_count", int'(bus.count), 0);
        check("async_ovf", int'(bus.ovf_sticky), 0);
        m = 0; m_ovf = 0; m_wrap = 0;
        #1 rst = 1'b0;
        // load then overflow past hi, wrap and saturate
        set_in(0, 1, 2, 0, 1, 11, 3, 12, 0); tick();
        check("t2_load", int'(bus.count), 11);
        set_in(1, 1, 2, 0, 0, 11, 3, 12, 0); tick();
        check("t2_wrap", int'(bus.count), 3);
        check("t2_wrap_p", int'(bus.wrap_p), 1);
        set_in(0, 1, 2, 0, 1, 11, 3, 12, 1); tick();
        set_in(1, 1, 2, 0, 0, 11, 3, 12, 1); tick();
        check("t2_sat", int'(bus.count), 12);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_sat_hold", int'(bus.count), 12);
            check("t2_sat_pulse", int'(bus.wrap_p), 1);
        end
        // downward crossings and exact landing on lo
        set_in(0, 0, 3, 0, 1, 5, 3, 12, 0); tick();
        set_in(1, 0, 3, 0, 0, 5, 3, 12, 0); tick();
        check("t3_wrap", int'(bus.count), 12);
        set_in(0, 0, 3, 0, 1, 5, 3, 12, 1); tick();
        set_in(1, 0, 3, 0, 0, 5, 3, 12, 1); tick();
        check("t3_sat", int'(bus.count), 3);
        set_in(0, 0, 3, 0, 1, 6, 3, 12, 0); tick();
        set_in(1, 0, 3, 0, 0, 6, 3, 12, 0); tick();
        check("t3_land", int'(bus.count), 3);
        check("t3_at_min", int'(bus.at_min), 1);
        check("t3_no_wrap", int'(bus.wrap_p), 0);
        // priority clr > load > en, and load clamping
        set_in(1, 1, 1, 1, 1, 9, 3, 12, 0); tick();
        check("t4_clr", int'(bus.count), 3);
        check("t4_clr_ovf", int'(bus.ovf_sticky), 0);
        set_in(1, 1, 1, 0, 1, 9, 3, 12, 0); tick();
        check("t4_load", int'(bus.count), 9);
        set_in(0, 1, 1, 0, 1, 14, 3, 12, 0); tick();
        check("t4_clamp", int'(bus.count), 12);
        // inverted limits freeze counting
        set_in(1, 1, 1, 0, 0, 0, 10, 5, 0);
        #1 check("t5_cfg_err", int'(bus.cfg_err), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_hold", int'(bus.count), 12);
            check("t5_wrap", int'(bus.wrap_p), 0);
        end
        set_in(1, 1, 1, 0, 0, 0, 0, 15, 0); tick();
        check("t5_resume", int'(bus.count), 13);
        // random regression
        void'($urandom(32'd1234));
        in_range = 0;
        for (int i = 0; i < 2000; i++) begin
            bus.en = 1'($urandom_range(0, 3) != 0);
            bus.up = 1'($urandom);
            bus.step = 2'($urandom);
            bus.clr = 1'($urandom_range(0, 31) == 0);
            bus.load = 1'($urandom_range(0, 15) == 0);
            bus.load_val = 4'($urandom);
            bus.sat_mode = 1'($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                bus.lo_limit = 4'($urandom_range(0, 7));
                bus.hi_limit = 4'($urandom_range(4, 15));
                in_range = 0;
            end
            tick();
            if (in_range && !bus.cfg_err)
                check("in_range", int'(bus.count >= bus.lo_limit && bus.count <= bus.hi_limit), 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
